// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a choice of registered or fall-through read data.
module sync_fifo_prog #(
   parameter int DSIZE    = 16,
   parameter int ADDRSIZE = 8,
   parameter int FWFT     = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DSIZE-1:0]    wdata,
   input  logic                winc,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   afull_th,
   input  logic [ADDRSIZE:0]   aempty_th,
   input  logic                clr_err,
   output logic [DSIZE-1:0]    rdata,
   output logic                wfull,
   output logic                rempty,
   output logic                wfull_almost,
   output logic                rempty_almost,
   output logic [ADDRSIZE:0]   count,
   output logic                overflow,
   output logic                underflow
);

   localparam int depth = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] full_count = {1'b1, {ADDRSIZE{1'b0}}};

   logic [DSIZE-1:0]    mem [depth];
   logic [ADDRSIZE-1:0] wptr;
   logic [ADDRSIZE-1:0] rptr;
   logic                wr_en;
   logic                rd_en;

   // Handshake: a write is accepted on an edge when winc=1 and wfull=0, a read when
   // rinc=1 and rempty=0. Rejected requests change nothing except the sticky error flags.
   assign wr_en = winc & ~wfull;
   assign rd_en = rinc & ~rempty;

   // All flags come from the registered count, so inputs never reach them combinationally
   // (thresholds excepted, which are compared directly).
   assign wfull         = (count == full_count);
   assign rempty        = (count == '0);
   assign wfull_almost  = (count >= afull_th);
   assign rempty_almost = (count <= aempty_th);

   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en) wptr <= wptr + ADDRSIZE'(1);
         if (rd_en) rptr <= rptr + ADDRSIZE'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (ADDRSIZE+1)'(1);
            2'b01:   count <= count - (ADDRSIZE+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A new error in the same cycle as clr_err wins over the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (winc && wfull)     overflow <= 1'b1;
         else if (clr_err)      overflow <= 1'b0;
         if (rinc && rempty)    underflow <= 1'b1;
         else if (clr_err)      underflow <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is always visible; only meaningful while rempty=0.
         assign rdata = mem[rptr];
      end else begin : g_std
         logic [DSIZE-1:0] rdata_q;
         always_ff @(posedge clk) begin
            if (!rst_n)     rdata_q <= '0;
            else if (rd_en) rdata_q <= mem[rptr];
         end
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one standard-read and one fall-through instance,
// read data checked through expected queues, status checked against hand-computed values.
module tb_sync_fifo_prog;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] afull_th = 3'd3;
   logic [2:0] aempty_th = 3'd1;
   logic       clr_err = 1'b0;

   logic [7:0] wdata0 = '0;
   logic       winc0 = 1'b0, rinc0 = 1'b0;
   logic [7:0] rdata0;
   logic       wfull0, rempty0, wfull_almost0, rempty_almost0, overflow0, underflow0;
   logic [2:0] count0;

   logic [7:0] wdata1 = '0;
   logic       winc1 = 1'b0, rinc1 = 1'b0;
   logic [7:0] rdata1;
   logic       wfull1, rempty1, wfull_almost1, rempty_almost1, overflow1, underflow1;
   logic [2:0] count1;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic       pend0 = 1'b0;
   int         n_pass = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   sync_fifo_prog #(.DSIZE(8), .ADDRSIZE(2), .FWFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wdata(wdata0), .winc(winc0), .rinc(rinc0),
      .afull_th(afull_th), .aempty_th(aempty_th), .clr_err(clr_err),
      .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .wfull_almost(wfull_almost0),
      .rempty_almost(rempty_almost0), .count(count0), .overflow(overflow0),
      .underflow(underflow0));

   sync_fifo_prog #(.DSIZE(8), .ADDRSIZE(2), .FWFT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wdata(wdata1), .winc(winc1), .rinc(rinc1),
      .afull_th(afull_th), .aempty_th(aempty_th), .clr_err(clr_err),
      .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .wfull_almost(wfull_almost1),
      .rempty_almost(rempty_almost1), .count(count1), .overflow(overflow1),
      .underflow(underflow1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Packed as {count, wfull, rempty, wfull_almost, rempty_almost, overflow, underflow}.
   task automatic st0(input string name, input logic [2:0] c, input bit f, input bit e,
                      input bit af, input bit ae, input bit ov, input bit un);
      check(name, {23'd0, count0, wfull0, rempty0, wfull_almost0, rempty_almost0,
                   overflow0, underflow0},
            {23'd0, c, f, e, af, ae, ov, un});
   endtask

   task automatic step0(input bit w, input bit r, input logic [7:0] d, input bit clr);
      winc0 = w; rinc0 = r; wdata0 = d; clr_err = clr;
      @(posedge clk); #1;
      winc0 = 1'b0; rinc0 = 1'b0; clr_err = 1'b0;
   endtask

   task automatic step1(input bit w, input bit r, input logic [7:0] d);
      winc1 = w; rinc1 = r; wdata1 = d;
      @(posedge clk); #1;
      winc1 = 1'b0; rinc1 = 1'b0;
   endtask

   // Standard-mode monitor: data is presented the cycle after an accepted read edge.
   always @(negedge clk) begin
      if (pend0) begin
         n_total++;
         if (exp_q0.size() == 0) begin
            $display("FAIL rdata0: got 0x%0h with nothing expected", rdata0);
         end else begin
            logic [7:0] e;
            e = exp_q0.pop_front();
            if (rdata0 === e) n_pass++;
            else $display("FAIL rdata0: got 0x%0h expected 0x%0h", rdata0, e);
         end
      end
      pend0 <= rst_n && rinc0 && !rempty0;
   end

   // Fall-through monitor: the displayed word is consumed when rinc meets rempty=0.
   always @(negedge clk) begin
      if (rst_n && rinc1 && !rempty1) begin
         n_total++;
         if (exp_q1.size() == 0) begin
            $display("FAIL rdata1: got 0x%0h with nothing expected", rdata1);
         end else begin
            logic [7:0] e;
            e = exp_q1.pop_front();
            if (rdata1 === e) n_pass++;
            else $display("FAIL rdata1: got 0x%0h expected 0x%0h", rdata1, e);
         end
      end
   end

   initial begin
      logic [7:0] wrap_exp [10];
      wrap_exp = '{8'h44, 8'h77, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      st0("reset_status", 3'd0, 0, 1, 0, 1, 0, 0);
      check("reset_rdata0", rdata0, 8'h00);
      check("reset_rempty1", rempty1, 1'b1);
      afull_th = 3'd0; #1;
      check("afull_th0_forces", wfull_almost0, 1'b1);
      afull_th = 3'd3; #1;

      // Fill to full, then overflow.
      step0(1, 0, 8'h11, 0); st0("fill1", 3'd1, 0, 0, 0, 1, 0, 0);
      step0(1, 0, 8'h22, 0); st0("fill2", 3'd2, 0, 0, 0, 0, 0, 0);
      step0(1, 0, 8'h33, 0); st0("fill3", 3'd3, 0, 0, 1, 0, 0, 0);
      step0(1, 0, 8'h44, 0); st0("fill4", 3'd4, 1, 0, 1, 0, 0, 0);
      step0(1, 0, 8'h55, 0); st0("overflow", 3'd4, 1, 0, 1, 0, 1, 0);
      aempty_th = 3'd4; #1;
      check("aempty_th4_forces", rempty_almost0, 1'b1);
      aempty_th = 3'd1; #1;

      // Drain, then underflow; rdata must hold the last word.
      exp_q0.push_back(8'h11); step0(0, 1, 8'h00, 0); st0("drain1", 3'd3, 0, 0, 1, 0, 1, 0);
      exp_q0.push_back(8'h22); step0(0, 1, 8'h00, 0); st0("drain2", 3'd2, 0, 0, 0, 0, 1, 0);
      exp_q0.push_back(8'h33); step0(0, 1, 8'h00, 0); st0("drain3", 3'd1, 0, 0, 0, 1, 1, 0);
      exp_q0.push_back(8'h44); step0(0, 1, 8'h00, 0); st0("drain4", 3'd0, 0, 1, 0, 1, 1, 0);
      step0(0, 1, 8'h00, 0); st0("underflow", 3'd0, 0, 1, 0, 1, 1, 1);
      step0(0, 0, 8'h00, 0);
      check("rdata_hold_underflow", rdata0, 8'h44);
      step0(0, 0, 8'h00, 1); st0("clr_both", 3'd0, 0, 1, 0, 1, 0, 0);

      // Full with simultaneous write/read: read wins, write rejected.
      step0(1, 0, 8'h11, 0); step0(1, 0, 8'h22, 0);
      step0(1, 0, 8'h33, 0); step0(1, 0, 8'h44, 0);
      st0("refill", 3'd4, 1, 0, 1, 0, 0, 0);
      exp_q0.push_back(8'h11); step0(1, 1, 8'h66, 0);
      st0("full_wr_rd", 3'd3, 0, 0, 1, 0, 1, 0);
      step0(0, 0, 8'h00, 1); st0("clr_ovf", 3'd3, 0, 0, 1, 0, 0, 0);
      step0(1, 0, 8'h77, 0); st0("full_again", 3'd4, 1, 0, 1, 0, 0, 0);
      step0(1, 0, 8'h99, 1); st0("set_wins_clr", 3'd4, 1, 0, 1, 0, 1, 0);
      step0(0, 0, 8'h00, 1); st0("clr_after", 3'd4, 1, 0, 1, 0, 0, 0);
      exp_q0.push_back(8'h22); step0(0, 1, 8'h00, 0);
      exp_q0.push_back(8'h33); step0(0, 1, 8'h00, 0);
      st0("at_two", 3'd2, 0, 0, 0, 0, 0, 0);

      // Simultaneous traffic at count 2 across several pointer wraps.
      for (int i = 0; i < 10; i++) begin
         exp_q0.push_back(wrap_exp[i]);
         step0(1, 1, 8'(8'h80 + i), 0);
         check("wrap_count", count0, 3'd2);
      end
      exp_q0.push_back(8'h88); step0(0, 1, 8'h00, 0);
      exp_q0.push_back(8'h89); step0(0, 1, 8'h00, 0);
      st0("wrap_drained", 3'd0, 0, 1, 0, 1, 0, 0);

      // Empty with simultaneous write/read: write wins, underflow set.
      step0(1, 1, 8'h5A, 0); st0("empty_wr_rd", 3'd1, 0, 0, 0, 1, 0, 1);
      exp_q0.push_back(8'h5A); step0(0, 1, 8'h00, 0);
      st0("empty_wr_rd_drain", 3'd0, 0, 1, 0, 1, 0, 1);

      // Reset mid-operation discards contents; write in the reset cycle is ignored.
      step0(1, 0, 8'h01, 0); step0(1, 0, 8'h02, 0); step0(1, 0, 8'h03, 0);
      st0("pre_reset", 3'd3, 0, 0, 1, 0, 0, 1);
      rst_n = 1'b0; winc0 = 1'b1; wdata0 = 8'h04;
      @(posedge clk); #1;
      rst_n = 1'b1; winc0 = 1'b0;
      st0("mid_reset", 3'd0, 0, 1, 0, 1, 0, 0);
      check("mid_reset_rdata0", rdata0, 8'h00);
      step0(0, 1, 8'h00, 0); st0("post_reset_underflow", 3'd0, 0, 1, 0, 1, 0, 1);

      // Fall-through instance.
      exp_q1.push_back(8'hA5); step1(1, 0, 8'hA5);
      check("fwft_rempty_after_wr", rempty1, 1'b0);
      check("fwft_rdata_no_rinc", rdata1, 8'hA5);
      step1(0, 1, 8'h00);
      check("fwft_rempty_after_rd", rempty1, 1'b1);
      exp_q1.push_back(8'hB1); step1(1, 0, 8'hB1);
      exp_q1.push_back(8'hB2); step1(1, 0, 8'hB2);
      check("fwft_count2", count1, 3'd2);
      step1(0, 1, 8'h00);
      step1(0, 1, 8'h00);
      check("fwft_empty_end", rempty1, 1'b1);
      check("fwft_no_underflow", underflow1, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      check("exp_q0_drained", exp_q0.size(), 0);
      check("exp_q1_drained", exp_q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
